// File: rtl/alu_cmp_arbiter.sv
// Round-robin arbiter sharing one SLT/SLTU-style compare datapath between two requesters.
// Optional macro CMP_ARB_FAST_EN removes the BUSY state (handshake -> response in one cycle).
module alu_cmp_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic              i_req0_uns,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic              i_req1_uns,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic              o_rsp_lt,
  output logic              o_rsp_eq,
  output logic [DATA_W-1:0] o_rsp_result,
  input  logic              i_rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              rr;
  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_lt;
  logic              rsp_eq;
  logic              gnt_valid;
  logic              gnt_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_uns;
  logic              out_gate;
`ifndef CMP_ARB_FAST_EN
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              uns_q;
  logic              id_q;
`endif

  // Returns {lt, eq}; the sign-differ rule keeps signed overflow out of the result.
  function automatic logic [1:0] cmp_lt_eq(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic              uns);
    logic [DATA_W:0] diff;
    logic            lt;
    diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    if (uns) begin
      lt = ~diff[DATA_W];
    end else if (a[DATA_W-1] != b[DATA_W-1]) begin
      lt = a[DATA_W-1];
    end else begin
      lt = diff[DATA_W-1];
    end
    return {lt, (diff[DATA_W-1:0] == {DATA_W{1'b0}})};
  endfunction

  // Combinational grant, only offered in IDLE and never while reset is asserted.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if ((state == IDLE) && !i_rst) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = rr;
      end else if (i_req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (i_req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end else begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
    end else begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
    end
  end

  assign sel_a   = gnt_id ? i_req1_a   : i_req0_a;
  assign sel_b   = gnt_id ? i_req1_b   : i_req0_b;
  assign sel_uns = gnt_id ? i_req1_uns : i_req0_uns;

  assign o_req0_ready = gnt_valid & ~gnt_id;
  assign o_req1_ready = gnt_valid &  gnt_id;

  // Response registers are forced quiet while reset is held so a discarded compare never shows.
  assign out_gate     = ~i_rst;
  assign o_rsp_valid  = rsp_valid & out_gate;
  assign o_rsp_id     = rsp_id    & out_gate;
  assign o_rsp_lt     = rsp_lt    & out_gate;
  assign o_rsp_eq     = rsp_eq    & out_gate;
  assign o_rsp_result = {{(DATA_W-1){1'b0}}, rsp_lt & out_gate};

  // Sequencing FSM with operand capture and registered response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
`ifndef CMP_ARB_FAST_EN
      a_q       <= {DATA_W{1'b0}};
      b_q       <= {DATA_W{1'b0}};
      uns_q     <= 1'b0;
      id_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            rr <= ~gnt_id;
`ifdef CMP_ARB_FAST_EN
            {rsp_lt, rsp_eq} <= cmp_lt_eq(sel_a, sel_b, sel_uns);
            rsp_id    <= gnt_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
`else
            a_q   <= sel_a;
            b_q   <= sel_b;
            uns_q <= sel_uns;
            id_q  <= gnt_id;
            state <= BUSY;
`endif
          end else begin
            state <= IDLE;
          end
        end
`ifndef CMP_ARB_FAST_EN
        BUSY: begin
          {rsp_lt, rsp_eq} <= cmp_lt_eq(a_q, b_q, uns_q);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`endif
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_eq    <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
